// File: rtl/pong_referee_if.sv
// Bundles the per-frame game signals between the ball block, the
// paddle controllers and the referee.
//   Inputs to the referee : frame_tick, start, ballx, bally, paddle_ly, paddle_ry
//   Outputs of the referee: ball_rst, hit_l, hit_r, goal_l, goal_r,
//                           score_l, score_r, state, winner
// The slave modport is used by the referee; the master modport by whoever
// drives the game inputs and consumes the results.
interface pong_referee_if;
    logic       frame_tick;
    logic       start;
    logic [9:0] ballx;
    logic [9:0] bally;
    logic [9:0] paddle_ly;
    logic [9:0] paddle_ry;
    logic       ball_rst;
    logic       hit_l;
    logic       hit_r;
    logic       goal_l;
    logic       goal_r;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [1:0] state;
    logic [1:0] winner;

    modport slave (
        input  frame_tick, start, ballx, bally, paddle_ly, paddle_ry,
        output ball_rst, hit_l, hit_r, goal_l, goal_r,
               score_l, score_r, state, winner
    );

    modport master (
        output frame_tick, start, ballx, bally, paddle_ly, paddle_ry,
        input  ball_rst, hit_l, hit_r, goal_l, goal_r,
               score_l, score_r, state, winner
    );
endinterface

// File: rtl/pong_referee.sv
// Pong game referee: detects paddle hits and goals once per video frame,
// keeps both scores and runs the IDLE/PAUSE/PLAY/OVER state machine.
// Ports:
//   clk  - system clock
//   rst  - synchronous, active-high reset
//   bus  - pong_referee_if.slave: frame inputs, hit/goal pulses, scores,
//          state, winner and ball_rst (holds the ball at centre outside PLAY)
// All outputs are registered; decisions taken on a frame_tick cycle show up
// one clock later and every pulse is exactly one clock wide.
module pong_referee #(
    parameter int PADDLE_LX    = 16,
    parameter int PADDLE_RX    = 616,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int BALL_SIZE    = 8,
    parameter int GOAL_LX      = 2,
    parameter int GOAL_RX      = 630,
    parameter int WIN_SCORE    = 7,
    parameter int PAUSE_FRAMES = 60
) (
    input  logic               clk,
    input  logic               rst,
    pong_referee_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [7:0] PAUSE_LOAD = 8'(PAUSE_FRAMES - 1);
    localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);

    state_t     state_q, state_d;
    logic [3:0] score_l_q, score_l_d;
    logic [3:0] score_r_q, score_r_d;
    logic [1:0] winner_q, winner_d;
    logic [7:0] pause_cnt_q, pause_cnt_d;
    logic       hit_l_lat_q, hit_l_lat_d;
    logic       hit_r_lat_q, hit_r_lat_d;
    logic       hit_l_q, hit_l_d;
    logic       hit_r_q, hit_r_d;
    logic       goal_l_q, goal_l_d;
    logic       goal_r_q, goal_r_d;
    logic       ball_rst_q, ball_rst_d;

    // 11-bit zero-extended copies so y + height can never wrap.
    logic [10:0] bx_s, by_s, ly_s, ry_s;
    logic        ov_l_s, ov_r_s, goal_l_cond_s, goal_r_cond_s;

    assign bx_s = {1'b0, bus.ballx};
    assign by_s = {1'b0, bus.bally};
    assign ly_s = {1'b0, bus.paddle_ly};
    assign ry_s = {1'b0, bus.paddle_ry};

    assign ov_l_s = (bx_s >= 11'(PADDLE_LX)) && (bx_s < 11'(PADDLE_LX + PADDLE_W)) &&
                    ((by_s + 11'(BALL_SIZE)) > ly_s) && (by_s < (ly_s + 11'(PADDLE_H)));
    assign ov_r_s = (bx_s >= 11'(PADDLE_RX)) && (bx_s < 11'(PADDLE_RX + PADDLE_W)) &&
                    ((by_s + 11'(BALL_SIZE)) > ry_s) && (by_s < (ry_s + 11'(PADDLE_H)));

    assign goal_l_cond_s = (bx_s <= 11'(GOAL_LX));
    assign goal_r_cond_s = (bx_s >= 11'(GOAL_RX));

    // Next-state and next-output computation; only frame_tick advances the game.
    always_comb begin
        state_d     = state_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        winner_d    = winner_q;
        pause_cnt_d = pause_cnt_q;
        hit_l_lat_d = hit_l_lat_q;
        hit_r_lat_d = hit_r_lat_q;
        hit_l_d     = 1'b0;
        hit_r_d     = 1'b0;
        goal_l_d    = 1'b0;
        goal_r_d    = 1'b0;

        if (bus.frame_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        pause_cnt_d = PAUSE_LOAD;
                        state_d     = ST_PAUSE;
                    end else begin
                        state_d     = ST_IDLE;
                    end
                end
                ST_PAUSE: begin
                    if (pause_cnt_q == 8'd0) begin
                        state_d     = ST_PLAY;
                    end else begin
                        pause_cnt_d = pause_cnt_q - 8'd1;
                    end
                end
                ST_PLAY: begin
                    // A goal frame never issues a hit pulse; leaving PLAY drops both latches.
                    if (goal_l_cond_s || goal_r_cond_s) begin
                        hit_l_lat_d = 1'b0;
                        hit_r_lat_d = 1'b0;
                        pause_cnt_d = PAUSE_LOAD;
                        state_d     = ST_PAUSE;
                        if (goal_l_cond_s) begin
                            goal_l_d  = 1'b1;
                            score_r_d = score_r_q + 4'd1;
                            if (score_r_d == WIN_VAL) begin
                                winner_d = 2'd2;
                                state_d  = ST_OVER;
                            end else begin
                                winner_d = winner_q;
                            end
                        end else begin
                            goal_r_d  = 1'b1;
                            score_l_d = score_l_q + 4'd1;
                            if (score_l_d == WIN_VAL) begin
                                winner_d = 2'd1;
                                state_d  = ST_OVER;
                            end else begin
                                winner_d = winner_q;
                            end
                        end
                    end else begin
                        // One pulse per contact: the latch blocks repeats until overlap ends.
                        hit_l_d     = ov_l_s && !hit_l_lat_q;
                        hit_l_lat_d = ov_l_s;
                        hit_r_d     = ov_r_s && !hit_r_lat_q;
                        hit_r_lat_d = ov_r_s;
                    end
                end
                ST_OVER: begin
                    if (bus.start) begin
                        score_l_d   = 4'd0;
                        score_r_d   = 4'd0;
                        winner_d    = 2'd0;
                        pause_cnt_d = PAUSE_LOAD;
                        state_d     = ST_PAUSE;
                    end else begin
                        state_d     = ST_OVER;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // Registered so ball_rst tracks the state register exactly.
        ball_rst_d = (state_d != ST_PLAY);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            score_l_q   <= 4'd0;
            score_r_q   <= 4'd0;
            winner_q    <= 2'd0;
            pause_cnt_q <= 8'd0;
            hit_l_lat_q <= 1'b0;
            hit_r_lat_q <= 1'b0;
            hit_l_q     <= 1'b0;
            hit_r_q     <= 1'b0;
            goal_l_q    <= 1'b0;
            goal_r_q    <= 1'b0;
            ball_rst_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            winner_q    <= winner_d;
            pause_cnt_q <= pause_cnt_d;
            hit_l_lat_q <= hit_l_lat_d;
            hit_r_lat_q <= hit_r_lat_d;
            hit_l_q     <= hit_l_d;
            hit_r_q     <= hit_r_d;
            goal_l_q    <= goal_l_d;
            goal_r_q    <= goal_r_d;
            ball_rst_q  <= ball_rst_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.score_l  = score_l_q;
    assign bus.score_r  = score_r_q;
    assign bus.winner   = winner_q;
    assign bus.hit_l    = hit_l_q;
    assign bus.hit_r    = hit_r_q;
    assign bus.goal_l   = goal_l_q;
    assign bus.goal_r   = goal_r_q;
    assign bus.ball_rst = ball_rst_q;

endmodule

// File: tb/tb_pong_referee.sv
// Self-checking bench for pong_referee: a table of per-frame vectors with
// hand-computed expectations, plus hand-written sequences for game over,
// restart and reset in mid-game.
module tb_pong_referee;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pong_referee_if rif ();

    pong_referee dut (
        .clk (clk),
        .rst (rst),
        .bus (rif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // n: number of frame_ticks applied (0 = one clock with no tick)
    typedef struct {
        int n;
        int st;
        int bx;
        int by;
        int ly;
        int ry;
        int e_st;
        int e_hl;
        int e_hr;
        int e_gl;
        int e_gr;
        int e_sl;
        int e_sr;
        int e_brst;
        int e_win;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int n, int st, int bx, int by, int ly, int ry,
                                int e_st, int e_hl, int e_hr, int e_gl, int e_gr,
                                int e_sl, int e_sr, int e_brst, int e_win);
        vec_t v;
        v.n = n; v.st = st; v.bx = bx; v.by = by; v.ly = ly; v.ry = ry;
        v.e_st = e_st; v.e_hl = e_hl; v.e_hr = e_hr; v.e_gl = e_gl; v.e_gr = e_gr;
        v.e_sl = e_sl; v.e_sr = e_sr; v.e_brst = e_brst; v.e_win = e_win;
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all(string tag, int e_st, int e_hl, int e_hr, int e_gl, int e_gr,
                             int e_sl, int e_sr, int e_brst, int e_win);
        chk({tag, ".state"},    int'(rif.state),    e_st);
        chk({tag, ".hit_l"},    int'(rif.hit_l),    e_hl);
        chk({tag, ".hit_r"},    int'(rif.hit_r),    e_hr);
        chk({tag, ".goal_l"},   int'(rif.goal_l),   e_gl);
        chk({tag, ".goal_r"},   int'(rif.goal_r),   e_gr);
        chk({tag, ".score_l"},  int'(rif.score_l),  e_sl);
        chk({tag, ".score_r"},  int'(rif.score_r),  e_sr);
        chk({tag, ".ball_rst"}, int'(rif.ball_rst), e_brst);
        chk({tag, ".winner"},   int'(rif.winner),   e_win);
    endtask

    // One clock, optionally with frame_tick; outputs are stable #1 after the edge.
    task automatic step(bit ft);
        rif.frame_tick = ft;
        @(posedge clk);
        #1;
        rif.frame_tick = 1'b0;
    endtask

    task automatic set_in(int st, int bx, int by, int ly, int ry);
        rif.start     = (st != 0);
        rif.ballx     = 10'(bx);
        rif.bally     = 10'(by);
        rif.paddle_ly = 10'(ly);
        rif.paddle_ry = 10'(ry);
    endtask

    // After a decision, one idle clock must bring every pulse back to 0.
    task automatic check_pulses_clear(string tag);
        step(1'b0);
        chk({tag, ".pulse_end"}, int'({rif.hit_l, rif.hit_r, rif.goal_l, rif.goal_r}), 0);
    endtask

    task automatic pause_to_play(string tag, int sl, int sr);
        set_in(0, 300, 240, 0, 0);
        repeat (59) step(1'b1);
        chk({tag, ".still_pause"}, int'(rif.state), 2);
        step(1'b1);
        check_all(tag, 1, 0, 0, 0, 0, sl, sr, 0, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        rif.frame_tick = 1'b0;
        set_in(0, 300, 240, 0, 0);

        // Reset for two cycles.
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("reset", 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // start without frame_tick changes nothing.
        rif.start = 1'b1;
        repeat (3) step(1'b0);
        check_all("start_no_tick", 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Serve: one tick with start -> PAUSE, then 60 ticks -> PLAY.
        step(1'b1);
        check_all("serve", 2, 0, 0, 0, 0, 0, 0, 1, 0);
        rif.start = 1'b0;
        pause_to_play("serve_pause", 0, 0);

        //              n  st  bx   by   ly   ry   st hl hr gl gr sl sr br win
        vecs.push_back(mk(1, 0, 18, 230, 200, 400, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 18, 230, 200, 400, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 18, 230, 200, 400, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 40, 230, 200, 400, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 18, 230, 200, 400, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 40, 230, 200, 400, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 18, 192, 200, 400, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 18, 193, 200, 400, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 40, 230, 200, 400, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 23, 230, 200, 400, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 24, 230, 200, 400, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 15, 230, 200, 400, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 620, 100, 400, 80, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 623, 100, 400, 80, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 624, 100, 400, 80, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3,  400, 200, 200, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 629, 400, 200, 200, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 630, 400, 200, 200, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 630, 400, 200, 200, 2, 0, 0, 0, 1, 1, 0, 1, 0));
        vecs.push_back(mk(60, 1, 300, 240, 200, 200, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0,  400, 200, 200, 2, 0, 0, 1, 0, 1, 1, 1, 0));
        vecs.push_back(mk(60, 0, 300, 240, 200, 200, 1, 0, 0, 0, 0, 1, 1, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            set_in(vecs[i].st, vecs[i].bx, vecs[i].by, vecs[i].ly, vecs[i].ry);
            if (vecs[i].n == 0) begin
                step(1'b0);
            end else begin
                repeat (vecs[i].n) step(1'b1);
            end
            check_all(tag, vecs[i].e_st, vecs[i].e_hl, vecs[i].e_hr, vecs[i].e_gl,
                      vecs[i].e_gr, vecs[i].e_sl, vecs[i].e_sr, vecs[i].e_brst, vecs[i].e_win);
            check_pulses_clear(tag);
        end
        set_in(0, 300, 240, 200, 200);

        // Drive score_r up to 6.
        for (int s = 2; s <= 6; s++) begin
            set_in(0, 0, 400, 200, 200);
            step(1'b1);
            check_all($sformatf("goal_l_%0d", s), 2, 0, 0, 1, 0, 1, s, 1, 0);
            pause_to_play($sformatf("pause_%0d", s), 1, s);
        end

        // Seventh goal ends the game.
        set_in(0, 1, 400, 200, 200);
        step(1'b1);
        check_all("game_over", 3, 0, 0, 1, 0, 1, 7, 1, 2);
        check_pulses_clear("game_over");
        step(1'b1);
        check_all("over_hold", 3, 0, 0, 0, 0, 1, 7, 1, 2);

        // Restart clears scores and winner.
        set_in(1, 300, 240, 200, 200);
        step(1'b1);
        check_all("restart", 2, 0, 0, 0, 0, 0, 0, 1, 0);
        pause_to_play("restart_pause", 0, 0);

        // Three right goals -> score_l = 3, back in PLAY.
        for (int s = 1; s <= 3; s++) begin
            set_in(0, 630, 400, 200, 200);
            step(1'b1);
            check_all($sformatf("goal_r_%0d", s), 2, 0, 0, 0, 1, s, 0, 1, 0);
            pause_to_play($sformatf("rpause_%0d", s), s, 0);
        end

        // Reset coincident with a frame_tick and a goal condition.
        set_in(0, 630, 400, 200, 200);
        rst = 1'b1;
        rif.frame_tick = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rif.frame_tick = 1'b0;
        check_all("mid_reset", 0, 0, 0, 0, 0, 0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
